// File: rtl/dram_cache_fill_arbiter_if.sv
// Request, AXI write-channel and B-response signals shared by the DRAM-cache fill arbiter
// and its neighbours (tag comparator, refill path, DRAM-cache memory controller).
interface dram_cache_fill_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 2,
  parameter int unsigned TAG_SIZE   = 22
);
  logic                             fill_valid_i;
  logic                             fill_ready_o;
  logic [ADDR_WIDTH+DATA_WIDTH-1:0] fill_data_i;
  logic                             refill_valid_i;
  logic                             refill_ready_o;
  logic [ADDR_WIDTH+DATA_WIDTH-1:0] refill_data_i;
  logic [ID_WIDTH-1:0]              awid_o;
  logic [ADDR_WIDTH-1:0]            awaddr_o;
  logic                             awvalid_o;
  logic                             awready_i;
  logic [TAG_SIZE+DATA_WIDTH-1:0]   wdata_o;
  logic                             wlast_o;
  logic                             wvalid_o;
  logic                             wready_i;
  logic [ID_WIDTH-1:0]              bid_i;
  logic                             bvalid_i;
  logic                             bready_o;

  modport master (
    input  fill_valid_i, fill_data_i, refill_valid_i, refill_data_i,
           awready_i, wready_i, bid_i, bvalid_i,
    output fill_ready_o, refill_ready_o, awid_o, awaddr_o, awvalid_o,
           wdata_o, wlast_o, wvalid_o, bready_o
  );

  modport slave (
    output fill_valid_i, fill_data_i, refill_valid_i, refill_data_i,
           awready_i, wready_i, bid_i, bvalid_i,
    input  fill_ready_o, refill_ready_o, awid_o, awaddr_o, awvalid_o,
           wdata_o, wlast_o, wvalid_o, bready_o
  );
endinterface

// File: rtl/dram_cache_fill_arbiter.sv
// Round-robin arbiter sharing the DRAM-cache write channel between tag-comparator fills and
// main-memory refills; formats the tag word and issues single-beat AXI writes, bounded by B count.
module dram_cache_fill_arbiter #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ID_WIDTH        = 2,
  parameter int unsigned TAG_WIDTH       = 16,
  parameter int unsigned BLANK_WIDTH     = 4,
  parameter int unsigned INDEX_WIDTH     = 10,
  parameter int unsigned OFFSET_WIDTH    = 6,
  parameter int unsigned TAG_SIZE        = 2 + TAG_WIDTH + BLANK_WIDTH,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  dram_cache_fill_arbiter_if.master bus,
  output logic                      err_o
);

  localparam int unsigned REQ_WIDTH = ADDR_WIDTH + DATA_WIDTH;
  localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);
  localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'((64'd1 << OFFSET_WIDTH) - 64'd1);

  typedef enum logic {S_IDLE, S_SEND} state_t;
  typedef enum logic {SRC_FILL, SRC_REFILL} src_t;

  state_t                         state;
  src_t                           last_grant;
  logic                           ret_q;
  logic [3:0]                     out_cnt;
  logic                           awvalid_q;
  logic                           wvalid_q;
  logic [ID_WIDTH-1:0]            awid_q;
  logic [ADDR_WIDTH-1:0]          awaddr_q;
  logic [TAG_SIZE+DATA_WIDTH-1:0] wdata_q;
  logic                           err_q;

  logic                           can_grant;
  logic                           grant_fill;
  logic                           grant_refill;
  logic [REQ_WIDTH-1:0]           sel_data;
  logic [ADDR_WIDTH-1:0]          sel_addr;
  logic [ADDR_WIDTH-1:0]          cache_addr;
  logic                           dirty;
  logic [ADDR_WIDTH-1:0]          fmt_awaddr;
  logic [TAG_SIZE+DATA_WIDTH-1:0] fmt_wdata;
  logic                           aw_hs;
  logic                           w_hs;
  logic                           b_hs;
  logic                           send_done;
  logic                           unused_bid;

  // ret_q blocks granting in the cycle right after a write completes.
  always_comb begin
    can_grant    = rst_n && (state == S_IDLE) && !ret_q && (out_cnt < MAX_CNT);
    grant_fill   = can_grant && bus.fill_valid_i &&
                   (!bus.refill_valid_i || (last_grant == SRC_REFILL));
    grant_refill = can_grant && bus.refill_valid_i &&
                   (!bus.fill_valid_i || (last_grant == SRC_FILL));
    sel_data     = grant_refill ? bus.refill_data_i : bus.fill_data_i;
    sel_addr     = sel_data[REQ_WIDTH-1 -: ADDR_WIDTH];
    cache_addr   = {1'b0, sel_addr[ADDR_WIDTH-2:0]};
    dirty        = grant_fill && sel_addr[ADDR_WIDTH-1];
    fmt_awaddr   = cache_addr & ~OFFSET_MASK;
    fmt_wdata    = {1'b1, dirty, cache_addr[ADDR_WIDTH-1:INDEX_WIDTH+OFFSET_WIDTH],
                    {BLANK_WIDTH{1'b0}}, sel_data[DATA_WIDTH-1:0]};
  end

  assign aw_hs     = awvalid_q && bus.awready_i;
  assign w_hs      = wvalid_q && bus.wready_i;
  assign b_hs      = bus.bvalid_i && bus.bready_o;
  assign send_done = (!awvalid_q || bus.awready_i) && (!wvalid_q || bus.wready_i);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      last_grant <= SRC_REFILL;
      ret_q      <= 1'b0;
      out_cnt    <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      awid_q     <= '0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      ret_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_fill || grant_refill) begin
            awaddr_q   <= fmt_awaddr;
            wdata_q    <= fmt_wdata;
            awid_q     <= grant_refill ? ID_WIDTH'(1) : '0;
            last_grant <= grant_refill ? SRC_REFILL : SRC_FILL;
            awvalid_q  <= 1'b1;
            wvalid_q   <= 1'b1;
            state      <= S_SEND;
          end
        end
        S_SEND: begin
          if (aw_hs) awvalid_q <= 1'b0;
          if (w_hs)  wvalid_q  <= 1'b0;
          if (send_done) begin
            state <= S_IDLE;
            ret_q <= 1'b1;
          end
        end
      endcase

      case ({aw_hs, b_hs})
        2'b10:   out_cnt <= out_cnt + 4'd1;
        2'b01:   out_cnt <= out_cnt - 4'd1;
        default: out_cnt <= out_cnt;
      endcase

      if (bus.bvalid_i && (out_cnt == '0)) err_q <= 1'b1;
    end
  end

  assign bus.fill_ready_o   = grant_fill;
  assign bus.refill_ready_o = grant_refill;
  assign bus.awid_o         = awid_q;
  assign bus.awaddr_o       = awaddr_q;
  assign bus.awvalid_o      = awvalid_q;
  assign bus.wdata_o        = wdata_q;
  assign bus.wlast_o        = 1'b1;
  assign bus.wvalid_o       = wvalid_q;
  assign bus.bready_o       = (out_cnt != '0);
  assign err_o              = err_q;
  assign unused_bid         = ^bus.bid_i;

endmodule
